// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- stall/flush controller for a five-stage pipeline.
//
// Decides every cycle which pipeline registers load, which get a NOP
// and when a UART transfer is launched. Three situations hold the
// front end: a UART access in MEM (whole pipe frozen until the transfer
// completes), a multi-cycle FPU op in EX (front end frozen, MEM fed
// bubbles) and a load-use hazard (one-cycle front-end stall). A taken
// branch in EX flushes IF/ID and ID/EX.
//
// Ports
//   CLK, reset                 clock; synchronous active-high reset
//   id_rs, id_rt               source registers of the ID instruction
//   id_uses_rs, id_uses_rt     ID instruction actually reads rs / rt
//   ex_valid                   EX holds a real instruction
//   ex_MemRead, ex_dst         EX instruction is a load / its destination
//   ex_AorF                    EX instruction is a multi-cycle FPU op
//   ex_branch_taken            branch/jump resolved taken in EX
//   mem_uart_req               MEM instruction talks to the UART
//   uart_done                  UART transfer complete (pulse)
//   pc_enable .. wb_enable     stage register load enables
//   squash_id, bubble_ex,
//   bubble_mem                 load a NOP into IF/ID, ID/EX, EX/MEM
//   uart_start                 one-cycle UART transfer request
//   stall_count                cycles with pc_enable=0 since reset
//   state_dbg                  current FSM state (0 RUN, 1 UART_WAIT,
//                              2 FPU_WAIT)
//
// Handshake: uart_start is raised for exactly the cycle the controller
// leaves RUN for UART_WAIT; the UART answers with a uart_done pulse in
// some later cycle. A uart_done coinciding with uart_start is ignored.
module pipeline_ctrl #(
    parameter int FPU_LAT = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_valid,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_dst,
    input  logic        ex_AorF,
    input  logic        ex_branch_taken,
    input  logic        mem_uart_req,
    input  logic        uart_done,
    output logic        pc_enable,
    output logic        inst_enable,
    output logic        ex_enable,
    output logic        mem_enable,
    output logic        wb_enable,
    output logic        squash_id,
    output logic        bubble_ex,
    output logic        bubble_mem,
    output logic        uart_start,
    output logic [31:0] stall_count,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] UART_WAIT = 2'd1;
    localparam logic [1:0] FPU_WAIT  = 2'd2;

    // The entry cycle in RUN is the first stall cycle, so the counter
    // covers the remaining FPU_LAT-2 stalls before the release cycle.
    localparam logic [3:0] CNT_INIT = 4'(FPU_LAT - 2);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic load_use;

    assign load_use = ex_valid && ex_MemRead && (ex_dst != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_dst)) ||
                       (id_uses_rt && (id_rt == ex_dst)));

    always_comb begin
        pc_enable   = 1'b1;
        inst_enable = 1'b1;
        ex_enable   = 1'b1;
        mem_enable  = 1'b1;
        wb_enable   = 1'b1;
        squash_id   = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        uart_start  = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (reset) begin
            state_d = RUN;
            cnt_d   = 4'd0;
        end else begin
            // advance is set on every path where the pipe moves forward
            // and the branch / load-use rules must be applied.
            logic advance;
            advance = 1'b0;

            case (state_q)
                RUN: begin
                    if (mem_uart_req) begin
                        uart_start  = 1'b1;
                        pc_enable   = 1'b0;
                        inst_enable = 1'b0;
                        ex_enable   = 1'b0;
                        mem_enable  = 1'b0;
                        wb_enable   = 1'b0;
                        state_d     = UART_WAIT;
                    end else if (ex_valid && ex_AorF) begin
                        pc_enable   = 1'b0;
                        inst_enable = 1'b0;
                        ex_enable   = 1'b0;
                        bubble_mem  = 1'b1;
                        cnt_d       = CNT_INIT;
                        state_d     = FPU_WAIT;
                    end else begin
                        advance = 1'b1;
                    end
                end
                UART_WAIT: begin
                    if (uart_done) begin
                        advance = 1'b1;
                        state_d = RUN;
                    end else begin
                        pc_enable   = 1'b0;
                        inst_enable = 1'b0;
                        ex_enable   = 1'b0;
                        mem_enable  = 1'b0;
                        wb_enable   = 1'b0;
                    end
                end
                FPU_WAIT: begin
                    // MEM only sees bubbles here, so mem_uart_req is
                    // deliberately not looked at.
                    if (cnt_q != 4'd0) begin
                        pc_enable   = 1'b0;
                        inst_enable = 1'b0;
                        ex_enable   = 1'b0;
                        bubble_mem  = 1'b1;
                        cnt_d       = cnt_q - 4'd1;
                    end else begin
                        advance = 1'b1;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase

            if (advance) begin
                // A taken branch discards the ID instruction anyway, so
                // a concurrent load-use hazard needs no stall.
                if (ex_branch_taken) begin
                    squash_id = 1'b1;
                    bubble_ex = 1'b1;
                end else if (load_use) begin
                    pc_enable   = 1'b0;
                    inst_enable = 1'b0;
                    bubble_ex   = 1'b1;
                end
            end
        end

        if (reset) begin
            stall_count_d = 32'd0;
        end else if (!pc_enable) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    always_ff @(posedge CLK) begin
        state_q       <= state_d;
        cnt_q         <= cnt_d;
        stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl -- directed scoreboard bench for pipeline_ctrl
// (FPU_LAT = 4). The driver applies one input vector per cycle just
// after the rising edge and pushes the hand-computed expected outputs;
// the monitor pops and compares on the falling edge.
module tb_pipeline_ctrl;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_UART = 2'd1;
    localparam logic [1:0] S_FPU  = 2'd2;

    logic        CLK;
    logic        reset;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rs, id_uses_rt;
    logic        ex_valid, ex_MemRead;
    logic [4:0]  ex_dst;
    logic        ex_AorF, ex_branch_taken;
    logic        mem_uart_req, uart_done;
    logic        pc_enable, inst_enable, ex_enable, mem_enable, wb_enable;
    logic        squash_id, bubble_ex, bubble_mem, uart_start;
    logic [31:0] stall_count;
    logic [1:0]  state_dbg;

    pipeline_ctrl #(.FPU_LAT(4)) dut (
        .CLK             (CLK),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_valid        (ex_valid),
        .ex_MemRead      (ex_MemRead),
        .ex_dst          (ex_dst),
        .ex_AorF         (ex_AorF),
        .ex_branch_taken (ex_branch_taken),
        .mem_uart_req    (mem_uart_req),
        .uart_done       (uart_done),
        .pc_enable       (pc_enable),
        .inst_enable     (inst_enable),
        .ex_enable       (ex_enable),
        .mem_enable      (mem_enable),
        .wb_enable       (wb_enable),
        .squash_id       (squash_id),
        .bubble_ex       (bubble_ex),
        .bubble_mem      (bubble_mem),
        .uart_start      (uart_start),
        .stall_count     (stall_count),
        .state_dbg       (state_dbg)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard ----------------
    // {en[4:0] = pc,inst,ex,mem,wb ; fl[3:0] = squash,bubble_ex,bubble_mem,
    //  uart_start ; state[1:0] ; stall_count[31:0]}
    localparam int W = 43;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v, got_v;
            string        nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            got_v = {pc_enable, inst_enable, ex_enable, mem_enable, wb_enable,
                     squash_id, bubble_ex, bubble_mem, uart_start,
                     state_dbg, stall_count};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got en=%b fl=%b st=%0d sc=%0d, want en=%b fl=%b st=%0d sc=%0d",
                         nm, got_v[42:38], got_v[37:34], got_v[33:32], got_v[31:0],
                         exp_v[42:38], exp_v[37:34], exp_v[33:32], exp_v[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_valid = 1'b0; ex_MemRead = 1'b0; ex_dst = 5'd0; ex_AorF = 1'b0;
        ex_branch_taken = 1'b0; mem_uart_req = 1'b0; uart_done = 1'b0;
    endtask

    task automatic load_in_ex(input logic [4:0] dst);
        ex_valid = 1'b1; ex_MemRead = 1'b1; ex_dst = dst;
    endtask

    // Inputs for the current cycle are already applied; record the
    // expected outputs and move to the next cycle.
    task automatic expect_cycle(input string nm, input logic [4:0] en,
                                input logic [3:0] fl, input logic [1:0] st,
                                input logic [31:0] sc);
        exp_q.push_back({en, fl, st, sc});
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        idle();
        @(posedge CLK); #1;
        expect_cycle("reset_state", 5'b11111, 4'b0000, S_RUN, 32'd0);
        reset = 1'b0;
        expect_cycle("idle", 5'b11111, 4'b0000, S_RUN, 32'd0);

        // load-use on rs
        load_in_ex(5'd5); id_rs = 5'd5; id_uses_rs = 1'b1;
        expect_cycle("lu_rs_stall", 5'b00111, 4'b0100, S_RUN, 32'd0);
        ex_valid = 1'b0; ex_MemRead = 1'b0;
        expect_cycle("lu_rs_after", 5'b11111, 4'b0000, S_RUN, 32'd1);

        // load-use on rt
        idle(); load_in_ex(5'd7); id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd5;
        expect_cycle("lu_rt_stall", 5'b00111, 4'b0100, S_RUN, 32'd1);
        id_uses_rt = 1'b0;
        expect_cycle("lu_rt_unused", 5'b11111, 4'b0000, S_RUN, 32'd2);

        // register zero never creates a hazard
        idle(); load_in_ex(5'd0); id_rs = 5'd0; id_uses_rs = 1'b1;
        expect_cycle("lu_r0", 5'b11111, 4'b0000, S_RUN, 32'd2);
        idle(); ex_MemRead = 1'b1; ex_dst = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
        expect_cycle("lu_not_valid", 5'b11111, 4'b0000, S_RUN, 32'd2);
        idle(); ex_valid = 1'b1; ex_dst = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
        expect_cycle("not_a_load", 5'b11111, 4'b0000, S_RUN, 32'd2);

        // branch wins over load-use
        idle(); load_in_ex(5'd5); id_rs = 5'd5; id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
        expect_cycle("branch_vs_lu", 5'b11111, 4'b1100, S_RUN, 32'd2);

        // FPU op (with a branch flag that must lose to it)
        idle(); ex_valid = 1'b1; ex_AorF = 1'b1; ex_branch_taken = 1'b1;
        expect_cycle("fpu_enter", 5'b00011, 4'b0010, S_RUN, 32'd2);
        ex_branch_taken = 1'b0;
        expect_cycle("fpu_wait1", 5'b00011, 4'b0010, S_FPU, 32'd3);
        mem_uart_req = 1'b1;
        expect_cycle("fpu_wait2_uart_ignored", 5'b00011, 4'b0010, S_FPU, 32'd4);
        mem_uart_req = 1'b0;
        expect_cycle("fpu_release", 5'b11111, 4'b0000, S_FPU, 32'd5);
        idle();
        expect_cycle("fpu_back_run", 5'b11111, 4'b0000, S_RUN, 32'd5);

        // UART, done after 5 cycles; done in the start cycle is ignored
        mem_uart_req = 1'b1; uart_done = 1'b1;
        expect_cycle("uart_start", 5'b00000, 4'b0001, S_RUN, 32'd5);
        uart_done = 1'b0;
        for (int i = 0; i < 4; i++)
            expect_cycle("uart_wait", 5'b00000, 4'b0000, S_UART, 32'd6 + 32'(i));
        uart_done = 1'b1;
        expect_cycle("uart_done", 5'b11111, 4'b0000, S_UART, 32'd10);
        idle();
        expect_cycle("uart_back_run", 5'b11111, 4'b0000, S_RUN, 32'd10);

        // UART done coinciding with a taken branch
        mem_uart_req = 1'b1;
        expect_cycle("uart2_start", 5'b00000, 4'b0001, S_RUN, 32'd10);
        expect_cycle("uart2_wait", 5'b00000, 4'b0000, S_UART, 32'd11);
        uart_done = 1'b1; ex_branch_taken = 1'b1;
        expect_cycle("uart2_done_branch", 5'b11111, 4'b1100, S_UART, 32'd12);
        idle();
        expect_cycle("uart2_back_run", 5'b11111, 4'b0000, S_RUN, 32'd12);

        // reset abandons a UART wait
        mem_uart_req = 1'b1;
        expect_cycle("uart3_start", 5'b00000, 4'b0001, S_RUN, 32'd12);
        mem_uart_req = 1'b0;
        expect_cycle("uart3_wait", 5'b00000, 4'b0000, S_UART, 32'd13);
        reset = 1'b1; mem_uart_req = 1'b1;
        expect_cycle("reset_mid_uart", 5'b11111, 4'b0000, S_UART, 32'd14);
        reset = 1'b0; mem_uart_req = 1'b0;
        expect_cycle("after_reset", 5'b11111, 4'b0000, S_RUN, 32'd0);
        uart_done = 1'b1;
        expect_cycle("late_done_ignored", 5'b11111, 4'b0000, S_RUN, 32'd0);
        idle();
        expect_cycle("final_idle", 5'b11111, 4'b0000, S_RUN, 32'd0);

        // drain: the monitor must have consumed every expectation
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
